// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10-bit shift, ack capture.
// Latency: ps2_clk_oe rises the cycle after acceptance; data bits follow device clock falls.
// Backpressure: tx_ready is low from acceptance until the cycle after tx_done.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);

  localparam logic [CW-1:0] L_INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] L_TIMEOUT  = CW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] L_FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Line index 0 = PS/2 clock, 1 = PS/2 data.
  logic [1:0]    w_pad;
  logic [1:0]    r_sync0;
  logic [1:0]    r_sync1;
  logic [1:0]    r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_clk_filt_d;
  logic          w_fall;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;
  logic          r_ack;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_tx_ready;
  logic          r_tx_done;
  logic          r_tx_err;

  assign w_pad = {ps2_data_in, ps2_clk_in};

  for (genvar g = 0; g < 2; g++) begin : g_cond
    // Two-flop synchronizer followed by a run-length filter; both idle high like the bus.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync0[g] <= 1'b1;
        r_sync1[g] <= 1'b1;
        r_filt[g]  <= 1'b1;
        r_fcnt[g]  <= '0;
      end else begin
        r_sync0[g] <= w_pad[g];
        r_sync1[g] <= r_sync0[g];
        if (r_sync1[g] == r_filt[g]) begin
          r_fcnt[g] <= '0;
        end else if (r_fcnt[g] == L_FLT_LAST) begin
          r_filt[g] <= r_sync1[g];
          r_fcnt[g] <= '0;
        end else begin
          r_fcnt[g] <= r_fcnt[g] + FW'(1);
        end
      end
    end
  end

  // Delayed filtered clock for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clk_filt_d <= 1'b1;
    else        r_clk_filt_d <= r_filt[0];
  end

  assign w_fall = r_clk_filt_d & ~r_filt[0];

  // Transfer sequencer; all bus and handshake outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ack      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          // tx_ready stays low through the tx_done cycle, so acceptance waits one cycle.
          if (r_tx_ready && tx_valid) begin
            r_shift    <= {1'b1, ~^tx_data, tx_data};
            r_cnt      <= '0;
            r_tx_ready <= 1'b0;
            r_tx_err   <= 1'b0;
            r_clk_oe   <= 1'b1;
            r_state    <= S_INHIBIT;
          end else begin
            r_tx_ready <= 1'b1;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == L_INH_LAST) begin
            r_data_oe <= 1'b1;
            r_state   <= S_START;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_START: begin
          // Release the clock; the start bit (data low) stays driven.
          r_clk_oe  <= 1'b0;
          r_bit_cnt <= '0;
          r_cnt     <= '0;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (r_cnt == L_TIMEOUT) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_tx_done <= 1'b1;
            r_tx_err  <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_fall) begin
            r_data_oe <= ~r_shift[0];
            r_shift   <= {1'b0, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_cnt     <= '0;
            if (r_bit_cnt == 4'd9) r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ACK: begin
          r_data_oe <= 1'b0;
          if (r_cnt == L_TIMEOUT) begin
            r_clk_oe  <= 1'b0;
            r_tx_done <= 1'b1;
            r_tx_err  <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_fall) begin
            r_ack   <= ~r_filt[1];
            r_cnt   <= '0;
            r_state <= S_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (r_filt == 2'b11) begin
            r_tx_done <= 1'b1;
            r_tx_err  <= ~r_ack;
            r_state   <= S_IDLE;
          end else if (r_cnt == L_TIMEOUT) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_tx_done <= 1'b1;
            r_tx_err  <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_ready    = r_tx_ready;
  assign tx_done     = r_tx_done;
  assign tx_err      = r_tx_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device-side bus model, table vectors, random bytes, corner sequences.
// Timing: 10-unit clock; device half period H core cycles.
// Open-drain bus is modelled as wired-AND of host oe and device release.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int FLT = 8;
  localparam int TMO = 400;
  localparam int H   = 40;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;

  logic dev_clk;
  logic dev_data;

  int n_chk;
  int n_fail;

  int   done_cnt;
  logic last_err;
  logic ready_after;
  logic done_prev;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completion monitor: counts done pulses, latches err and the following tx_ready.
  initial begin
    done_cnt    = 0;
    last_err    = 1'b0;
    ready_after = 1'b0;
    done_prev   = 1'b0;
  end
  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      last_err <= tx_err;
    end
    if (done_prev === 1'b1) ready_after <= tx_ready;
    done_prev <= tx_done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame as the device sees it, bit 0 first: 8 data bits, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = ((ones % 2) == 0);
    return {1'b1, par, d};
  endfunction

  // Accept a byte, check inhibit/start timing, then clock nfalls bits out as the device.
  task automatic do_xfer(input logic [7:0] d, input int nfalls, input bit glitch,
                         input bit ack, output logic [9:0] rx);
    int n;
    int fd;
    rx = '0;
    n  = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
    n  = 0;
    fd = 0;
    while (ps2_clk_oe === 1'b1 && n < 200) begin
      n++;
      if (ps2_data_oe === 1'b1 && fd == 0) fd = n;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH + 1);
    chk("start_bit_pos", fd, INH + 1);
    chk("start_bit_held", 32'(ps2_data_oe), 32'd1);
    repeat (10) @(negedge clk);
    chk("no_early_data", 32'(ps2_data_oe), 32'd1);
    for (int i = 0; i < nfalls; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      rx[i]   = ps2_data_in;
      dev_clk = 1'b1;
      if (glitch && i == 3) begin
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H - H / 2 - 3) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    if (nfalls == 10) begin
      dev_data = ~ack;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
    end
  endtask

  task automatic run_full(input string tag, input logic [7:0] d, input bit ack, input bit glitch,
                          input logic exp_err, input logic [9:0] exp_frame);
    logic [9:0] rx;
    int         d0;
    d0 = done_cnt;
    do_xfer(d, 10, glitch, ack, rx);
    repeat (40) @(negedge clk);
    chk({tag, "_frame"}, 32'(rx), 32'(exp_frame));
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_err"}, 32'(last_err), 32'(exp_err));
    chk({tag, "_ready_after_done"}, 32'(ready_after), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         glitch;
    logic       exp_err;
    logic [9:0] exp_frame;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [9:0] rx;
    int         n;
    logic [7:0] rd;
    bit         rack;
    bit         rgl;

    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    vecs[0] = '{data: 8'hED, ack: 1'b1, glitch: 1'b0, exp_err: 1'b0, exp_frame: 10'h3ED};
    vecs[1] = '{data: 8'h01, ack: 1'b0, glitch: 1'b0, exp_err: 1'b1, exp_frame: 10'h201};
    vecs[2] = '{data: 8'hFF, ack: 1'b1, glitch: 1'b1, exp_err: 1'b0, exp_frame: 10'h3FF};
    vecs[3] = '{data: 8'h00, ack: 1'b1, glitch: 1'b0, exp_err: 1'b0, exp_frame: 10'h300};
    vecs[4] = '{data: 8'hA5, ack: 1'b1, glitch: 1'b1, exp_err: 1'b0, exp_frame: 10'h3A5};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(tx_ready), 32'd1);
    chk("reset_done", 32'(tx_done), 32'd0);
    chk("reset_err", 32'(tx_err), 32'd0);
    chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("reset_data_oe", 32'(ps2_data_oe), 32'd0);

    for (int v = 0; v < 5; v++) begin
      run_full($sformatf("vec%0d", v), vecs[v].data, vecs[v].ack, vecs[v].glitch,
               vecs[v].exp_err, vecs[v].exp_frame);
    end

    // Device stops clocking after fall 4; host must time out and release.
    do_xfer(8'hE0, 4, 1'b0, 1'b0, rx);
    chk("to_partial_bits", 32'(rx[3:0]), 32'(ref_frame(8'hE0) & 10'h00F));
    chk("to_data_driven", 32'(ps2_data_oe), 32'd1);
    n = 0;
    while (tx_done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("to_done_seen", 32'(tx_done), 32'd1);
    chk("to_window", 32'(n >= 300 && n <= 360), 32'd1);
    chk("to_err", 32'(tx_err), 32'd1);
    chk("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("to_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("to_ready_in_done", 32'(tx_ready), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    @(negedge clk);
    chk("to_ready_next", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("to_accepted_ready", 32'(tx_ready), 32'd0);
    chk("to_accepted_clk_oe", 32'(ps2_clk_oe), 32'd1);
    chk("to_err_cleared", 32'(tx_err), 32'd0);
    // No device at all: times out in SEND.
    n = 0;
    while (tx_done !== 1'b1 && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("nodev_done", 32'(tx_done), 32'd1);
    chk("nodev_err", 32'(tx_err), 32'd1);
    repeat (5) @(negedge clk);

    // Reset mid-SEND after fall 5; data line is being driven low for bit 4.
    do_xfer(8'h00, 5, 1'b0, 1'b0, rx);
    chk("rst_pre_data_oe", 32'(ps2_data_oe), 32'd1);
    chk("rst_pre_bits", 32'(rx[4:0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_async_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);

    for (int r = 0; r < 6; r++) begin
      rd   = 8'($urandom);
      rack = 1'($urandom);
      rgl  = 1'($urandom);
      run_full($sformatf("rnd%0d", r), rd, rack, rgl, ~rack, ref_frame(rd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter; sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain PS/2 clock/data pair. It is the outbound counterpart to the receive path. It filters the device-driven clock the same way the receive path filters its inputs. It runs the inhibit / request-to-send / bit-shift / acknowledge sequence and reports completion or error to the command logic.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000, cycles clock line is held low before request-to-send (100 µs at 50 MHz)
- FILTER_LEN, 8, consecutive equal synchronized samples needed to update a filtered line
- TIMEOUT_CYCLES, 750000, max cycles between device clock falling edges, and the max wait for the bus to return idle (15 ms at 50 MHz)

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- ps2_clk_in  in  1  raw PS/2 clock pad level (asynchronous)
- ps2_data_in  in  1  raw PS/2 data pad level (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
- ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  byte to send
- tx_ready  out  1  idle, may accept a byte
- tx_done  out  1  one-cycle pulse, transfer finished (success or error)
- tx_err  out  1  qualified by tx_done: 1 = no ack or timeout

## Operation
- Input conditioning, applied to each of ps2_clk_in and ps2_data_in:
  - 2-FF synchronizer, reset value 1.
  - Filter counter; the filtered value takes the synchronized value only after FILTER_LEN consecutive equal samples. Filtered reset value 1.
  - fall = filtered clock 1→0, a one-cycle pulse.
- Frame: shift register {stop=1, parity, data[7:0]}, LSB first.
  - parity = ~^tx_data (odd parity).
- States:
  - IDLE: tx_ready=1; both oe=0. On tx_valid, latch the frame, clear the counter, go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1. After INHIBIT_CYCLES cycles go to START.
  - START: one cycle with ps2_clk_oe=1 and ps2_data_oe=1 (start bit). Then go to SEND with bit_cnt=0 and the timeout counter cleared.
  - SEND: ps2_clk_oe=0. On each fall:
    - ps2_data_oe ← ~shift[0]; shift right; bit_cnt+1.
    - Falls 1–8 drive the data bits, fall 9 drives parity, fall 10 drives stop (data released).
    - After fall 10 go to ACK.
  - ACK: both oe=0. On the next fall, capture ack = ~filtered data, then go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock=1 and filtered data=1. Then pulse tx_done with tx_err=~ack and go to IDLE.
- Timeout:
  - In SEND and ACK, the counter clears on every fall.
  - In WAIT_IDLE, the counter runs from entry.
  - When the counter reaches TIMEOUT_CYCLES: both oe=0, tx_done=1 with tx_err=1, go to IDLE.
- tx_valid while tx_ready=0 is ignored. tx_data is sampled only on acceptance.
- Reset, including mid-transfer: both oe=0 immediately (asynchronous), state IDLE, tx_ready=1, tx_done=0, tx_err=0, filters=1.
- Counter width: $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1). Counters never wrap.

## Timing
- Acceptance edge k → ps2_clk_oe=1 from k+1 for exactly INHIBIT_CYCLES cycles.
- Next cycle (START): ps2_data_oe=1 and ps2_clk_oe still 1. After that cycle ps2_clk_oe=0 and ps2_data_oe stays 1.
- Data output changes the cycle after a fall pulse. A fall pulse trails the pad edge by 2 synchronizer cycles + FILTER_LEN cycles.
- tx_ready returns 1 the cycle after tx_done.
- A new tx_valid is acceptable in that same cycle, giving back-to-back transfers.
- tx_err is held until the next acceptance. tx_done is a single cycle.

## Test plan
- Send 0xED with a device model (clock period 80 µs) that drives ack low on clock 11.
  - Device samples bits 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - tx_done=1 with tx_err=0; tx_ready=1 on the next cycle.
- Inhibit timing with INHIBIT_CYCLES=20.
  - ps2_clk_oe is high for exactly 21 cycles; ps2_data_oe rises in the 21st.
  - No data change before the first device fall.
- Send 0x01 and check parity.
  - Device receives parity bit 0.
  - With the device not acking (data stays high at fall 11): tx_done with tx_err=1.
- Device stops clocking after fall 4.
  - After TIMEOUT_CYCLES: both oe=0, tx_done=1, tx_err=1, IDLE.
  - tx_valid is accepted on the next cycle.
- Glitch rejection: inject a clock glitch shorter than FILTER_LEN cycles during SEND.
  - No bit is shifted; the frame is still received correctly.
- Assert rst_n=0 mid-SEND, after fall 5.
  - Both oe drop to 0 without waiting for a clock edge.
  - After release: tx_ready=1, tx_done=0, tx_err=0.
